// File: rtl/card_display_bank.sv
// card_display_bank: bank of dealt-card registers, each driving one active-low
// 7-segment digit. Cards are loaded over a valid/ready port. The bank also
// provides a registered decode, a multi-cycle clear sweep, blinking of the
// most recently dealt card, and a sticky flag for out-of-range slot loads.
//
// Ports:
//   clk, resetb          clock, asynchronous active-low reset
//   load_valid/ready     load handshake (load_ready is combinational)
//   load_slot, load_card target slot index and card code (0 none, 1..13, 14/15 invalid)
//   clear_all            pulse that starts the slot-by-slot clear sweep
//   blink_en             enables blanking of the most recently loaded slot
//   card_out             stored codes, 4 bits per slot
//   hex_out              segments {g,f,e,d,c,b,a}, active-low, 7 bits per slot
//   busy                 high while the clear sweep runs
//   err_slot             sticky: a load targeted a nonexistent slot
module card_display_bank #(
    parameter int unsigned NUM_SLOTS     = 6,
    parameter int unsigned BLINK_HALF    = 25000000,
    parameter int unsigned BLINK_FLASHES = 3,
    localparam int unsigned SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [SLOT_W-1:0]      load_slot,
    input  logic [3:0]             load_card,
    input  logic                   clear_all,
    input  logic                   blink_en,
    output logic [4*NUM_SLOTS-1:0] card_out,
    output logic [7*NUM_SLOTS-1:0] hex_out,
    output logic                   busy,
    output logic                   err_slot
);

    localparam int unsigned CNT_W  = $clog2(BLINK_HALF + 1);
    localparam int unsigned PH_MAX = 2 * BLINK_FLASHES;
    localparam int unsigned PH_W   = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W:0]   SLOT_LIM  = (SLOT_W + 1)'(NUM_SLOTS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_HALF - 1);
    localparam logic [PH_W-1:0]   PH_START  = PH_W'(PH_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [NUM_SLOTS-1:0][3:0]     card_q;
    logic [NUM_SLOTS-1:0][6:0]     hex_q;
    logic [SLOT_W-1:0]             clear_idx_q;
    logic [SLOT_W-1:0]             fresh_q;
    logic [CNT_W-1:0]              phase_cnt_q;
    logic [PH_W-1:0]               phases_q;
    logic                          busy_q;
    logic                          err_q;

    logic accept;
    logic legal;
    logic clear_done;
    logic blank_now;

    // Active-low glyphs; 14/15 show an error glyph.
    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] seg;
        case (c)
            4'd0:    seg = 7'b1111111;
            4'd1:    seg = 7'b0001000;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            4'd10:   seg = 7'b1000000;
            4'd11:   seg = 7'b1100001;
            4'd12:   seg = 7'b0011000;
            4'd13:   seg = 7'b0001001;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Handshake qualifiers; clear_all blocks a same-cycle load.
    always_comb begin
        load_ready = (state_q == IDLE) && !clear_all;
        accept     = load_valid && load_ready;
        legal      = ({1'b0, load_slot} < SLOT_LIM);
        clear_done = (state_q == CLEAR) && (clear_idx_q == LAST_SLOT);
        // Even remaining-phase counts are the blank phases (first phase is blank).
        blank_now  = (phases_q != '0) && !phases_q[0];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_all) state_d = CLEAR;
            CLEAR:   if (clear_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Card storage, clear sweep pointer and flags.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            card_q      <= '0;
            clear_idx_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            busy_q <= (state_d == CLEAR);
            if (state_q == CLEAR) begin
                card_q[clear_idx_q] <= 4'd0;
                clear_idx_q         <= clear_done ? '0 : clear_idx_q + SLOT_W'(1);
            end else begin
                clear_idx_q <= '0;
                if (accept && legal) begin
                    card_q[load_slot] <= load_card;
                end
            end
            if (clear_done) begin
                err_q <= 1'b0;
            end else if (accept && !legal) begin
                err_q <= 1'b1;
            end
        end
    end

    // Blink sequencer: phase timer plus remaining-phase count for the fresh slot.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            fresh_q     <= '0;
            phase_cnt_q <= '0;
            phases_q    <= '0;
        end else if (accept && legal) begin
            fresh_q     <= load_slot;
            phase_cnt_q <= '0;
            phases_q    <= PH_START;
        end else if (clear_done) begin
            phase_cnt_q <= '0;
            phases_q    <= '0;
        end else if (phases_q != '0) begin
            if (phase_cnt_q == CNT_LAST) begin
                phase_cnt_q <= '0;
                phases_q    <= phases_q - PH_W'(1);
            end else begin
                phase_cnt_q <= phase_cnt_q + CNT_W'(1);
            end
        end
    end

    // Registered decode, blanking the fresh slot during blank phases.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            hex_q <= '1;
        end else begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                if (blink_en && blank_now && (fresh_q == SLOT_W'(i))) begin
                    hex_q[i] <= 7'b1111111;
                end else begin
                    hex_q[i] <= decode(card_q[i]);
                end
            end
        end
    end

    assign card_out = card_q;
    assign hex_out  = hex_q;
    assign busy     = busy_q;
    assign err_slot = err_q;

endmodule

// File: tb/tb_card_display_bank.sv
// Self-checking bench for card_display_bank with a cycle-level reference model.
module tb_card_display_bank;

    localparam int N  = 6;
    localparam int BH = 4;
    localparam int BF = 2;

    localparam logic [6:0] DEC [16] = '{
        7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
        7'b0011000, 7'b0001001, 7'b0001110, 7'b0001110
    };

    logic           clk;
    logic           resetb;
    logic           load_valid;
    logic           load_ready;
    logic [2:0]     load_slot;
    logic [3:0]     load_card;
    logic           clear_all;
    logic           blink_en;
    logic [4*N-1:0] card_out;
    logic [7*N-1:0] hex_out;
    logic           busy;
    logic           err_slot;

    card_display_bank #(
        .NUM_SLOTS    (N),
        .BLINK_HALF   (BH),
        .BLINK_FLASHES(BF)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_slot (load_slot),
        .load_card (load_card),
        .clear_all (clear_all),
        .blink_en  (blink_en),
        .card_out  (card_out),
        .hex_out   (hex_out),
        .busy      (busy),
        .err_slot  (err_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [3:0]     card_m [N];
    bit             err_m;
    bit             clearing_m;
    int             clear_pos;
    int             fresh_m;
    int             since_m;
    logic [7*N-1:0] hex_e;
    int             n_checks;
    int             n_fail;

    // Blank when t cycles have passed since the load and the phase index is even.
    function automatic bit blank_at(input int t);
        if (t < 0) return 1'b0;
        return ((t / BH) < 2 * BF) && (((t / BH) % 2) == 0);
    endfunction

    function automatic logic [4*N-1:0] cards_e();
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) r[4*i +: 4] = card_m[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) card_m[i] = 4'd0;
        err_m      = 1'b0;
        clearing_m = 1'b0;
        clear_pos  = 0;
        fresh_m    = 0;
        since_m    = -1;
        hex_e      = '1;
    endtask

    task automatic drive(input bit v, input int slot, input int card, input bit clr);
        load_valid = v;
        load_slot  = 3'(slot);
        load_card  = 4'(card);
        clear_all  = clr;
    endtask

    // One clock edge: advance DUT and model together; returns #1 after the edge.
    task automatic tick();
        logic [3:0] pre_card [N];
        bit         ready_pre;
        bit         blank_pre;
        int         fresh_pre;
        bit         ben;
        bit         v;
        logic [2:0] slot;
        logic [3:0] card;
        bit         clr;
        pre_card  = card_m;
        ready_pre = !clearing_m && !clear_all;
        blank_pre = blank_at(since_m);
        fresh_pre = fresh_m;
        ben       = blink_en;
        v         = load_valid;
        slot      = load_slot;
        card      = load_card;
        clr       = clear_all;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            hex_e[7*i +: 7] = (ben && blank_pre && fresh_pre == i) ? 7'h7f : DEC[pre_card[i]];
        if (since_m >= 0) since_m++;
        if (clearing_m) begin
            card_m[clear_pos] = 4'd0;
            if (clear_pos == N - 1) begin
                clearing_m = 1'b0;
                err_m      = 1'b0;
                since_m    = -1;
            end else begin
                clear_pos++;
            end
        end else if (clr) begin
            clearing_m = 1'b1;
            clear_pos  = 0;
        end
        if (v && ready_pre) begin
            if (int'(slot) < N) begin
                card_m[slot] = card;
                fresh_m      = int'(slot);
                since_m      = 0;
            end else begin
                err_m = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        resetb   = 1'b0;
        blink_en = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (hex_out !== {7*N{1'b1}}) begin n_fail++; $display("FAIL reset_hex got %h want all ones", hex_out); end
        n_checks++; if (card_out !== '0) begin n_fail++; $display("FAIL reset_card got %h want 0", card_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (err_slot !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_slot); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", load_ready); end
        #2 resetb = 1'b1;
    endtask

    task automatic test_load_basic();
        drive(1, 0, 13, 0);
        tick();
        drive(0, 0, 0, 0);
        n_checks++; if (card_out[3:0] !== 4'd13) begin n_fail++; $display("FAIL load_card got %0d want 13", card_out[3:0]); end
        n_checks++; if (hex_out !== hex_e) begin n_fail++; $display("FAIL load_hex_early got %h want %h", hex_out, hex_e); end
        tick();
        n_checks++; if (hex_out[6:0] !== 7'b0001001) begin n_fail++; $display("FAIL load_hex got %b want 0001001", hex_out[6:0]); end
        n_checks++; if (hex_out !== hex_e) begin n_fail++; $display("FAIL load_hex_all got %h want %h", hex_out, hex_e); end
    endtask

    task automatic test_decode_walk();
        for (int c = 0; c < 16; c++) begin
            drive(1, 2, c, 0);
            tick();
            drive(0, 0, 0, 0);
            tick();
            n_checks++; if (hex_out[20:14] !== DEC[c]) begin n_fail++; $display("FAIL decode_%0d got %b want %b", c, hex_out[20:14], DEC[c]); end
            n_checks++; if (card_out !== cards_e()) begin n_fail++; $display("FAIL decode_card_%0d got %h want %h", c, card_out, cards_e()); end
        end
    endtask

    task automatic test_blink();
        logic [6:0] want;
        blink_en = 1'b1;
        drive(1, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            want = (((k - 1) / 4 == 0) || ((k - 1) / 4 == 2)) ? 7'b1111111 : 7'b0001000;
            n_checks++; if (hex_out[13:7] !== want) begin n_fail++; $display("FAIL blink_k%0d got %b want %b", k, hex_out[13:7], want); end
            n_checks++; if (hex_out !== hex_e) begin n_fail++; $display("FAIL blink_all_k%0d got %h want %h", k, hex_out, hex_e); end
        end
        blink_en = 1'b0;
    endtask

    task automatic test_bad_slot();
        int busy_cycles;
        drive(1, 6, 5, 0);
        tick();
        drive(0, 0, 0, 0);
        n_checks++; if (err_slot !== 1'b1) begin n_fail++; $display("FAIL bad_err got %b want 1", err_slot); end
        n_checks++; if (card_out !== cards_e()) begin n_fail++; $display("FAIL bad_card got %h want %h", card_out, cards_e()); end
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy === 1'b1) busy_cycles++;
            n_checks++; if (busy !== clearing_m) begin n_fail++; $display("FAIL clear_busy_k%0d got %b want %b", k, busy, clearing_m); end
            n_checks++; if (load_ready !== !clearing_m) begin n_fail++; $display("FAIL clear_ready_k%0d got %b want %b", k, load_ready, !clearing_m); end
            tick();
        end
        n_checks++; if (busy_cycles !== 6) begin n_fail++; $display("FAIL clear_len got %0d want 6", busy_cycles); end
        n_checks++; if (card_out !== '0) begin n_fail++; $display("FAIL clear_card got %h want 0", card_out); end
        n_checks++; if (hex_out !== {7*N{1'b1}}) begin n_fail++; $display("FAIL clear_hex got %h want all ones", hex_out); end
        n_checks++; if (err_slot !== 1'b0) begin n_fail++; $display("FAIL clear_err got %b want 0", err_slot); end
    endtask

    task automatic test_clear_vs_load();
        drive(1, 3, 7, 0);
        tick();
        drive(1, 4, 9, 1);
        tick();
        drive(0, 0, 0, 0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cvl_busy got %b want 1", busy); end
        repeat (7) tick();
        n_checks++; if (card_out !== '0) begin n_fail++; $display("FAIL cvl_card got %h want 0", card_out); end
        n_checks++; if (card_out !== cards_e()) begin n_fail++; $display("FAIL cvl_model got %h want %h", card_out, cards_e()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cvl_idle got %b want 0", busy); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) blink_en = 1'($urandom % 2);
            drive(($urandom % 3) == 0, int'($urandom % 8), int'($urandom % 16), ($urandom % 40) == 0);
            tick();
            n_checks++; if (card_out !== cards_e()) begin n_fail++; $display("FAIL rnd_card_%0d got %h want %h", k, card_out, cards_e()); end
            n_checks++; if (hex_out !== hex_e) begin n_fail++; $display("FAIL rnd_hex_%0d got %h want %h", k, hex_out, hex_e); end
            n_checks++; if (busy !== clearing_m) begin n_fail++; $display("FAIL rnd_busy_%0d got %b want %b", k, busy, clearing_m); end
            n_checks++; if (err_slot !== err_m) begin n_fail++; $display("FAIL rnd_err_%0d got %b want %b", k, err_slot, err_m); end
            n_checks++; if (load_ready !== (!clearing_m && !clear_all)) begin n_fail++; $display("FAIL rnd_ready_%0d got %b want %b", k, load_ready, !clearing_m && !clear_all); end
        end
        drive(0, 0, 0, 0);
        blink_en = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_async_reset();
        drive(1, 5, 8, 0);
        tick();
        drive(1, 7, 3, 0);
        tick();
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_busy_pre got %b want 1", busy); end
        #3 resetb = 1'b0;
        #1;
        model_reset();
        n_checks++; if (hex_out !== {7*N{1'b1}}) begin n_fail++; $display("FAIL ar_hex got %h want all ones", hex_out); end
        n_checks++; if (card_out !== '0) begin n_fail++; $display("FAIL ar_card got %h want 0", card_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b want 0", busy); end
        n_checks++; if (err_slot !== 1'b0) begin n_fail++; $display("FAIL ar_err got %b want 0", err_slot); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got %b want 1", load_ready); end
        @(posedge clk);
        #2 resetb = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_post_busy_%0d got %b want 0", k, busy); end
            n_checks++; if (card_out !== '0) begin n_fail++; $display("FAIL ar_post_card_%0d got %h want 0", k, card_out); end
            n_checks++; if (hex_out !== hex_e) begin n_fail++; $display("FAIL ar_post_hex_%0d got %h want %h", k, hex_out, hex_e); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_basic();
        test_decode_walk();
        test_blink();
        test_bad_slot();
        test_clear_vs_load();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/card_display_bank.md
Name: card_display_bank

Overview:
Multi-slot successor to the single-digit card decoder. Holds NUM_SLOTS dealt-card codes (player and dealer hands) in registers, loaded through a valid/ready port, and drives one active-low 7-segment digit per slot. Adds behaviour the single decoder lacks: a registered decode, a multi-cycle clear sweep, blinking of the most recently dealt card, and a sticky bad-slot flag. Sits between the Baccarat datapath and the DE1 HEX displays.

Parameters:
NUM_SLOTS, 6, number of card slots/digits; legal range 1..8
BLINK_HALF, 25000000, clk cycles per blink phase (blank or lit); must be >= 1
BLINK_FLASHES, 3, blank/lit flash pairs shown after each accepted load
SLOT_W, $clog2(NUM_SLOTS) with a minimum of 1, derived; slot index width

Ports:
clk  in  1  system clock; all state changes on its rising edge
resetb  in  1  asynchronous, active-low reset
load_valid  in  1  load request
load_ready  out  1  combinational: high when state is IDLE and clear_all is low
load_slot  in  SLOT_W  target slot index
load_card  in  4  card code: 0 none, 1 A, 2-10, 11 J, 12 Q, 13 K
clear_all  in  1  single-cycle pulse that starts the clear sweep
blink_en  in  1  1 enables blanking of the fresh slot
card_out  out  4*NUM_SLOTS  stored codes; slot i occupies bits [4i+3:4i]
hex_out  out  7*NUM_SLOTS  segments {g,f,e,d,c,b,a}, active-low; slot i occupies bits [7i+6:7i]
busy  out  1  high while the clear sweep runs
err_slot  out  1  sticky flag: a load targeted a slot index >= NUM_SLOTS

Behaviour:
- Reset (asynchronous, resetb=0): every card register is 0, hex_out is all 1s, state is IDLE, busy=0, err_slot=0, blink is inactive, fresh slot is 0.
- Handshake: a load is accepted on a rising edge when load_valid=1 and load_ready=1.
  - A legal slot is written with load_card on that edge; card_out reflects it immediately after the edge.
  - hex_out follows one edge later (registered decode).
  - If load_slot >= NUM_SLOTS, the load is accepted but dropped, and err_slot is set.
- Decode table (active-low):
  - 0 -> 1111111; 1 -> 0001000; 2 -> 0100100; 3 -> 0110000; 4 -> 0011001
  - 5 -> 0010010; 6 -> 0000010; 7 -> 1111000; 8 -> 0000000; 9 -> 0010000
  - 10 -> 1000000; 11 -> 1100001; 12 -> 0011000; 13 -> 0001001
  - 14 and 15 -> 0001110 (error glyph)
- State machine:
  - IDLE -> CLEAR when clear_all=1. clear_all has priority over a simultaneous load_valid; because load_ready is low, that load is not accepted.
  - CLEAR: zeroes slot 0, 1, ..., NUM_SLOTS-1, one slot per edge, so the sweep takes NUM_SLOTS cycles. busy=1 throughout.
  - The same edge that zeroes the last slot returns the state to IDLE, clears err_slot, and cancels blink.
  - clear_all asserted during CLEAR is ignored.
- Blink:
  - An accepted legal load makes that slot the fresh slot and sets the remaining phase count to 2*BLINK_FLASHES.
  - The phase counter restarts at 0 and the first phase is blank.
  - Each phase lasts BLINK_HALF cycles; the display alternates blank and lit, then stays lit once the count reaches 0.
  - A new legal load during a blink restarts the blink on the new slot; the previous fresh slot becomes steadily lit.
  - The counters run while blink_en=0, but no blanking is applied. Blank means that slot's hex_out field is 1111111.
- Width rules: the phase counter is sized $clog2(BLINK_HALF+1). It wraps to 0 at BLINK_HALF-1 with no overflow, and the phase count saturates at 0.
- Reset mid-sweep or mid-blink: same result as a normal reset; nothing resumes afterwards.

Test Plan:
- Settings for all scenarios: NUM_SLOTS=6, BLINK_HALF=4, BLINK_FLASHES=2.
- Release reset -> hex_out all 1s, load_ready=1, busy=0. Then load slot 0 with card 13, blink_en=0 -> card_out[3:0]=13 after the edge; hex_out[6:0]=0001001 one edge later.
- Walk load_card 0..15 into slot 2 -> each hex_out[20:14] matches the decode table, including 14/15 -> 0001110.
- blink_en=1, load slot 1 with card 1 -> hex_out[13:7] is 1111111 for 4 cycles, 0001000 for 4, 1111111 for 4, then steadily 0001000.
- Load slot 6 with card 5 -> err_slot=1; card_out unchanged. Then pulse clear_all -> busy=1 for 6 cycles, load_ready=0, every slot reads 0, err_slot=0.
- clear_all and load_valid asserted in the same cycle -> load not accepted, sweep runs, slot contents all 0.
- Assert resetb=0 in cycle 3 of the sweep -> all outputs return to reset values immediately, without waiting for a clock edge.
